bsg_muxi2_gatestack_arb: RTL

// Two-requester arbiter/sequencer that shares one bsg_muxi2_gatestack lane array between stream A and stream B.

---
 rtl/bsg_muxi2_gatestack_arb.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/bsg_muxi2_gatestack_arb.sv
// ---------------------------------------------------------------------------
// bsg_muxi2_gatestack_arb
//
// Purpose:
//   Two-requester arbiter/sequencer sharing one bsg_muxi2_gatestack lane
//   array between stream A and stream B. Each beat carries width_p lanes of
//   data plus a lane mask. A winner is picked each cycle, the gatestack
//   per-lane select is driven accordingly, and the selected result is
//   registered into a 1-entry output buffer with a valid/yumi handshake.
//
// Optional feature (compile-time macro):
//   BSG_MUXI2_GATESTACK_ARB_MERGE_EN
//     Defined   : when both streams are valid and their lane masks do not
//                 overlap, both beats are consumed in one cycle and merged
//                 lane-wise (lanes in b_mask_i come from B, the rest from A).
//     Undefined : never merge; each accepted beat comes from one stream.
//
// Ports:
//   clk_i     in   1        clock
//   reset_i   in   1        synchronous, active-high reset
//   a_v_i     in   1        stream A beat valid
//   a_data_i  in   width_p  stream A data
//   a_mask_i  in   width_p  stream A lane mask
//   a_yumi_o  out  1        stream A beat consumed this cycle
//   b_v_i     in   1        stream B beat valid
//   b_data_i  in   width_p  stream B data
//   b_mask_i  in   width_p  stream B lane mask
//   b_yumi_o  out  1        stream B beat consumed this cycle
//   v_o       out  1        output buffer valid
//   data_o    out  width_p  registered result
//   mask_o    out  width_p  registered lane mask of the result
//   src_o     out  2        {b_used, a_used} for the buffered beat
//   yumi_i    in   1        consumer takes the buffered beat (only when v_o=1)
//
// Handshake semantics (both sides):
//   A producer holds x_v_i/x_data_i/x_mask_i stable until it sees x_yumi_o=1
//   in the same cycle; x_yumi_o is a combinational "consumed now" strobe and
//   never asserts unless x_v_i=1. On the output side, the consumer may raise
//   yumi_i only while v_o=1; the buffered beat is retired on that clock edge.
//   A new beat may be accepted in the same cycle the old one is retired.
// ---------------------------------------------------------------------------

// Inverting 2:1 mux per lane: o = ~(i2 ? i1 : i0).
module bsg_muxi2_gatestack #(
  parameter int width_p = 16
) (
  input  logic [width_p-1:0] i0,
  input  logic [width_p-1:0] i1,
  input  logic [width_p-1:0] i2,
  output logic [width_p-1:0] o
);

  for (genvar i = 0; i < width_p; i++) begin : g_lane
    assign o[i] = ~(i2[i] ? i1[i] : i0[i]);
  end

endmodule

module bsg_muxi2_gatestack_arb #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,

  input  logic               a_v_i,
  input  logic [width_p-1:0] a_data_i,
  input  logic [width_p-1:0] a_mask_i,
  output logic               a_yumi_o,

  input  logic               b_v_i,
  input  logic [width_p-1:0] b_data_i,
  input  logic [width_p-1:0] b_mask_i,
  output logic               b_yumi_o,

  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic [width_p-1:0] mask_o,
  output logic [1:0]         src_o,
  input  logic               yumi_i
);

  // Output buffer occupancy.
  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  buf_state_e state_q, state_d;

  logic [width_p-1:0] data_q, data_d;
  logic [width_p-1:0] mask_q, mask_d;
  logic [1:0]         src_q,  src_d;
  logic               last_b_q, last_b_d;

  logic               space;
  logic               merge;
  logic               grant_a;
  logic               grant_b;
  logic               accept;
  logic [width_p-1:0] sel;
  logic [width_p-1:0] mux_o;

  // The buffer can take a beat when empty, or when its current beat is
  // being retired in this same cycle.
  assign space = (state_q == BUF_EMPTY) | yumi_i;

`ifdef BSG_MUXI2_GATESTACK_ARB_MERGE_EN
  assign merge = a_v_i & b_v_i & ~(|(a_mask_i & b_mask_i));
`else
  assign merge = 1'b0;
`endif

  // Round-robin: on contention, A wins when B was served last. A merge
  // serves both streams and is allowed to bypass the round-robin choice.
  // Grants are suppressed during reset so no beat is consumed and lost.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset_i && space) begin
      if (merge) begin
        grant_a = 1'b1;
        grant_b = 1'b1;
      end else if (a_v_i && b_v_i) begin
        grant_a = last_b_q;
        grant_b = ~last_b_q;
      end else begin
        grant_a = a_v_i;
        grant_b = b_v_i;
      end
    end
  end

  assign accept   = grant_a | grant_b;
  assign a_yumi_o = grant_a;
  assign b_yumi_o = grant_b;

  // Per-lane select: a merge takes B only where B's mask is set; a single
  // B grant takes every lane from B; otherwise every lane comes from A.
  always_comb begin
    sel = '0;
    if (merge) begin
      sel = b_mask_i;
    end else if (grant_b) begin
      sel = '1;
    end
  end

  // Feeding inverted data cancels the gatestack's output inversion, so
  // mux_o is the true per-lane (sel ? b : a).
  bsg_muxi2_gatestack #(
    .width_p (width_p)
  ) u_gatestack (
    .i0 (~a_data_i),
    .i1 (~b_data_i),
    .i2 (sel),
    .o  (mux_o)
  );

  // Buffer FSM and payload next-state.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    mask_d   = mask_q;
    src_d    = src_q;
    last_b_d = last_b_q;

    unique case (state_q)
      BUF_EMPTY: begin
        if (accept) state_d = BUF_FULL;
      end
      BUF_FULL: begin
        if (yumi_i && !accept) state_d = BUF_EMPTY;
      end
      default: state_d = BUF_EMPTY;
    endcase

    if (accept) begin
      data_d = mux_o;
      mask_d = (grant_a ? a_mask_i : '0) | (grant_b ? b_mask_i : '0);
      src_d  = {grant_b, grant_a};
      // A merge serves both streams, so it leaves the round-robin alone.
      if (!merge) last_b_d = grant_b;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= BUF_EMPTY;
      data_q   <= '0;
      mask_q   <= '0;
      src_q    <= '0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      src_q    <= src_d;
      last_b_q <= last_b_d;
    end
  end

  assign v_o    = (state_q == BUF_FULL);
  assign data_o = data_q;
  assign mask_o = mask_q;
  assign src_o  = src_q;

endmodule
